// File: rtl/hpdmc_dataseq_pkg.sv
// Shared constants and helpers for the HPDMC data-path sequencer.
// Timing defaults, idle mask value and counter sizing live here.
package hpdmc_dataseq_pkg;

   localparam int DEF_WL    = 1;
   localparam int DEF_RL    = 4;
   localparam int DEF_BURST = 2;
   localparam int DEF_TURN  = 1;

   localparam int          DATA_W    = 64;
   localparam int          MASK_W    = 8;
   localparam logic [7:0]  MASK_IDLE = 8'hFF;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } wbeat_t;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Wide enough for the longest turnaround load value.
   function automatic int cnt_width(input int wl, input int rl, input int burst, input int turn);
      return imax(1, $clog2(rl + wl + burst + turn + 1));
   endfunction

endpackage

// File: rtl/hpdmc_dataseq_delayline.sv
// DEPTH-stage 1-bit shift register; q is the OR of the last WIN stages,
// which turns a single issue pulse into a WIN-cycle window DEPTH-WIN+1 cycles later.
module hpdmc_dataseq_delayline #(
   parameter int DEPTH = 1,
   parameter int WIN   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q
);

   logic [DEPTH:1] vld_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_pipe <= '0;
      else
         vld_pipe <= DEPTH'({vld_pipe, din});
   end

   assign q = |vld_pipe[DEPTH:DEPTH-WIN+1];

endmodule

// File: rtl/hpdmc_dataseq.sv
// HPDMC data-path sequencer: times write beats, bus direction and read strobes.
// The write beat output is named dout because do is a reserved word.
module hpdmc_dataseq
   import hpdmc_dataseq_pkg::*;
#(
   parameter int WL    = DEF_WL,
   parameter int RL    = DEF_RL,
   parameter int BURST = DEF_BURST,
   parameter int TURN  = DEF_TURN
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        write,
   input  logic        read,
   output logic        write_safe,
   output logic        read_safe,
   input  logic [63:0] wdata_in,
   input  logic [7:0]  wmask_in,
   output logic        wdata_ack,
   output logic        direction,
   output logic [63:0] dout,
   output logic [7:0]  mo,
   input  logic [63:0] di,
   output logic [63:0] rdata,
   output logic        rdata_valid,
   output logic        proto_err
);

   localparam int CW = cnt_width(WL, RL, BURST, TURN);

   // Last guarded cycle offset after an issue; counter reaches zero one cycle later.
   localparam logic [CW-1:0] LD_SAME = CW'(BURST - 1);
   localparam logic [CW-1:0] LD_W2R  = CW'(WL + BURST + TURN);
   localparam logic [CW-1:0] LD_R2W  = CW'(imax(BURST - 1, RL + BURST + TURN - WL - 1));

   logic          wr_ok, rd_ok, illegal;
   logic [CW-1:0] wcnt, rcnt, wcnt_nxt, rcnt_nxt;
   wbeat_t        wb_q;

   function automatic logic [CW-1:0] cmax(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // A command is accepted only alone and only while its bus side is safe.
   assign wr_ok   = write & ~read & write_safe;
   assign rd_ok   = read & ~write & read_safe;
   assign illegal = (write | read) & ~(wr_ok | rd_ok);

   assign write_safe = (wcnt == '0);
   assign read_safe  = (rcnt == '0);

   always_comb begin
      wcnt_nxt = (wcnt == '0) ? '0 : wcnt - CW'(1);
      rcnt_nxt = (rcnt == '0) ? '0 : rcnt - CW'(1);
      if (wr_ok) begin
         wcnt_nxt = cmax(wcnt_nxt, LD_SAME);
         rcnt_nxt = cmax(rcnt_nxt, LD_W2R);
      end
      if (rd_ok) begin
         rcnt_nxt = cmax(rcnt_nxt, LD_SAME);
         wcnt_nxt = cmax(wcnt_nxt, LD_R2W);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wcnt      <= '0;
         rcnt      <= '0;
         proto_err <= 1'b0;
      end else begin
         wcnt <= wcnt_nxt;
         rcnt <= rcnt_nxt;
         if (illegal)
            proto_err <= 1'b1;
      end
   end

   hpdmc_dataseq_delayline #(.DEPTH(WL + BURST - 1), .WIN(BURST)) u_ack_dl (
      .clk (sys_clk),
      .rst (sys_rst),
      .din (wr_ok),
      .q   (wdata_ack)
   );

   // One extra stage in the window gives the DQS preamble before the first beat.
   hpdmc_dataseq_delayline #(.DEPTH(WL + BURST), .WIN(BURST + 1)) u_dir_dl (
      .clk (sys_clk),
      .rst (sys_rst),
      .din (wr_ok),
      .q   (direction)
   );

   hpdmc_dataseq_delayline #(.DEPTH(RL + BURST - 1), .WIN(BURST)) u_rv_dl (
      .clk (sys_clk),
      .rst (sys_rst),
      .din (rd_ok),
      .q   (rdata_valid)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wb_q.data <= '0;
         wb_q.mask <= MASK_IDLE;
         rdata     <= '0;
      end else begin
         if (wdata_ack) begin
            wb_q.data <= wdata_in;
            wb_q.mask <= wmask_in;
         end else begin
            wb_q.mask <= MASK_IDLE;
         end
         rdata <= di;
      end
   end

   assign dout = wb_q.data;
   assign mo   = wb_q.mask;

endmodule

// File: tb/tb_hpdmc_dataseq.sv
// Bench for hpdmc_dataseq: directed table, corner sequences and randomized
// traffic against a cycle-indexed expectation model.
module tb_hpdmc_dataseq;

   localparam int WL = 1, RL = 4, BURST = 2, TURN = 1;
   localparam int N = 1024;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        write, read;
   logic        write_safe, read_safe;
   logic [63:0] wdata_in;
   logic [7:0]  wmask_in;
   logic        wdata_ack, direction;
   logic [63:0] dout;
   logic [7:0]  mo;
   logic [63:0] di;
   logic [63:0] rdata;
   logic        rdata_valid, proto_err;

   hpdmc_dataseq #(.WL(WL), .RL(RL), .BURST(BURST), .TURN(TURN)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .write       (write),
      .read        (read),
      .write_safe  (write_safe),
      .read_safe   (read_safe),
      .wdata_in    (wdata_in),
      .wmask_in    (wmask_in),
      .wdata_ack   (wdata_ack),
      .direction   (direction),
      .dout        (dout),
      .mo          (mo),
      .di          (di),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .proto_err   (proto_err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_err = 0;
   int c;

   // expectation model: per-cycle windows plus "free from cycle" times
   bit          m_ack[N], m_dir[N], m_rv[N];
   logic [63:0] m_wd[N], m_di[N];
   logic [7:0]  m_wm[N];
   int          wr_free, rd_free;
   bit          m_perr;
   logic [63:0] m_do;

   logic        o_ack, o_dir, o_rv, o_perr, o_ws, o_rs;
   logic [63:0] o_do, o_rdata;
   logic [7:0]  o_mo;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      chk(nm, 64'(act), 64'(exp));
   endtask

   task automatic model_clear();
      foreach (m_ack[i]) begin
         m_ack[i] = 1'b0; m_dir[i] = 1'b0; m_rv[i] = 1'b0;
         m_wd[i] = '0; m_di[i] = '0; m_wm[i] = '0;
      end
      wr_free = 0; rd_free = 0; m_perr = 1'b0; m_do = '0; c = 0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      write = 1'b0; read = 1'b0; wdata_in = '0; wmask_in = '0; di = '0;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      model_clear();
   endtask

   // apply one cycle of inputs, check every output for this cycle, advance model
   task automatic step(input logic w, input logic r, input logic [63:0] wd,
                       input logic [7:0] wm, input logic [63:0] d);
      logic lw, lr;
      write = w; read = r; wdata_in = wd; wmask_in = wm; di = d;
      m_wd[c] = wd; m_wm[c] = wm; m_di[c] = d;
      @(negedge sys_clk);
      o_ack = wdata_ack; o_dir = direction; o_rv = rdata_valid; o_perr = proto_err;
      o_ws = write_safe; o_rs = read_safe; o_do = dout; o_mo = mo; o_rdata = rdata;
      chkb("wdata_ack", o_ack, m_ack[c]);
      chkb("direction", o_dir, m_dir[c]);
      chkb("rdata_valid", o_rv, m_rv[c]);
      chkb("write_safe", o_ws, c >= wr_free);
      chkb("read_safe", o_rs, c >= rd_free);
      chkb("proto_err", o_perr, m_perr);
      chk("dout", o_do, m_do);
      chk("mo", 64'(o_mo), 64'((c > 0 && m_ack[c-1]) ? m_wm[c-1] : 8'hFF));
      chk("rdata", o_rdata, (c == 0) ? 64'h0 : m_di[c-1]);
      lw = w && !r && (c >= wr_free);
      lr = r && !w && (c >= rd_free);
      if (m_ack[c]) m_do = m_wd[c];
      if ((w || r) && !(lw || lr)) m_perr = 1'b1;
      if (lw) begin
         for (int k = 0; k < BURST; k++) m_ack[c+WL+k] = 1'b1;
         for (int k = 0; k <= BURST; k++) m_dir[c+WL+k] = 1'b1;
         wr_free = imax(wr_free, c + BURST);
         rd_free = imax(rd_free, c + WL + BURST + TURN + 1);
      end
      if (lr) begin
         for (int k = 0; k < BURST; k++) m_rv[c+RL+k] = 1'b1;
         rd_free = imax(rd_free, c + BURST);
         wr_free = imax(wr_free, c + imax(BURST, RL + BURST + TURN - WL));
      end
      @(posedge sys_clk);
      #1 c++;
   endtask

   typedef struct {
      logic w, r;
      logic [63:0] wd;
      logic [7:0] wm;
      logic e_ack, e_dir, e_ws, e_rs, e_rv, e_perr;
      logic [63:0] e_do;
      logic [7:0] e_mo;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic r, input logic [63:0] wd,
                               input logic [7:0] wm, input logic ea, input logic ed,
                               input logic ews, input logic ers, input logic erv,
                               input logic ep, input logic [63:0] edo, input logic [7:0] emo);
      vec_t v;
      v.w = w; v.r = r; v.wd = wd; v.wm = wm;
      v.e_ack = ea; v.e_dir = ed; v.e_ws = ews; v.e_rs = ers; v.e_rv = erv; v.e_perr = ep;
      v.e_do = edo; v.e_mo = emo;
      return v;
   endfunction

   initial begin
      vec_t tbl[14];
      logic [63:0] A, B, J;
      bit dirs[8], acks[8];
      int nrv;
      logic w, r;
      A = 64'hAAAA_0000_1111_2222;
      B = 64'hBBBB_3333_4444_5555;
      J = 64'h0;
      //             w     r     wd wm     ack   dir   ws    rs    rv    perr  do   mo
      tbl[0]  = mk(1'b1, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, J, 8'hFF);
      tbl[1]  = mk(1'b0, 1'b0, A, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, J, 8'hFF);
      tbl[2]  = mk(1'b0, 1'b0, B, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A, 8'h0F);
      tbl[3]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, B, 8'hF0);
      tbl[4]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, B, 8'hFF);
      tbl[5]  = mk(1'b0, 1'b1, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, B, 8'hFF);
      tbl[6]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B, 8'hFF);
      tbl[7]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, B, 8'hFF);
      tbl[8]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, B, 8'hFF);
      tbl[9]  = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B, 8'hFF);
      tbl[10] = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B, 8'hFF);
      tbl[11] = mk(1'b1, 1'b1, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, B, 8'hFF);
      tbl[12] = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, B, 8'hFF);
      tbl[13] = mk(1'b0, 1'b0, J, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, B, 8'hFF);

      // directed table: write, read, then a same-cycle read+write
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].wd, tbl[i].wm, 64'h100 + 64'(i));
         chkb("tbl_ack", o_ack, tbl[i].e_ack);
         chkb("tbl_dir", o_dir, tbl[i].e_dir);
         chkb("tbl_wsafe", o_ws, tbl[i].e_ws);
         chkb("tbl_rsafe", o_rs, tbl[i].e_rs);
         chkb("tbl_rvalid", o_rv, tbl[i].e_rv);
         chkb("tbl_perr", o_perr, tbl[i].e_perr);
         chk("tbl_do", o_do, tbl[i].e_do);
         chk("tbl_mo", 64'(o_mo), 64'(tbl[i].e_mo));
         chk("tbl_rdata", o_rdata, (i == 0) ? 64'h0 : 64'h100 + 64'(i - 1));
      end

      // back-to-back writes: one continuous direction window, single preamble
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(i == 0 || i == 2, 1'b0, 64'($urandom), 8'h00, '0);
         dirs[i] = o_dir;
         acks[i] = o_ack;
      end
      for (int i = 0; i < 8; i++) begin
         chkb("b2b_dir", dirs[i], i >= 1 && i <= 5);
         chkb("b2b_ack", acks[i], i >= 1 && i <= 4);
      end

      // read while read_safe is low after a write
      do_reset();
      step(1'b1, 1'b0, '0, 8'h00, '0);
      step(1'b0, 1'b0, '0, 8'h00, '0);
      step(1'b0, 1'b1, '0, 8'h00, '0);
      step(1'b0, 1'b0, '0, 8'h00, '0);
      chkb("illegal_rd_perr", o_perr, 1'b1);
      nrv = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, '0, 8'h00, '0);
         nrv += int'(o_rv);
      end
      chk("illegal_rd_nvalid", 64'(nrv), 64'd0);
      chkb("illegal_rd_sticky", o_perr, 1'b1);

      // reset asserted mid-burst
      do_reset();
      step(1'b1, 1'b0, 64'h1234, 8'h00, 64'h55);
      step(1'b0, 1'b0, 64'h5678, 8'h00, 64'h66);
      sys_rst = 1'b1;
      #1;
      chkb("rst_ack", wdata_ack, 1'b0);
      chkb("rst_dir", direction, 1'b0);
      chk("rst_do", dout, 64'h0);
      chk("rst_mo", 64'(mo), 64'hFF);
      chk("rst_rdata", rdata, 64'h0);
      chkb("rst_rvalid", rdata_valid, 1'b0);
      chkb("rst_wsafe", write_safe, 1'b1);
      chkb("rst_rsafe", read_safe, 1'b1);
      chkb("rst_perr", proto_err, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 8'h00, '0);

      // randomized traffic; later segments allow illegal commands
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int i = 0; i < 400; i++) begin
            w = ($urandom % 100) < 35;
            r = ($urandom % 100) < 30;
            if (seg < 2) begin
               if (c < wr_free) w = 1'b0;
               if (c < rd_free) r = 1'b0;
               if (w && r) r = 1'b0;
            end
            step(w, r, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
